mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Input-side companion to the MAC result interleaver in the lab6 matrix–vector datapath. It accepts a single serial stream of signed 8-bit operands, latches the 8-element vector B, and de-interleaves the matrix A stream into two parallel MAC lanes. Lane 1 computes even rows and lane 0 computes odd rows. Both lanes share the same B element. Downstream, the two lanes' 19-bit accumulations are serialised back into one stream by the result interleaver.

## Interface
Parameters:
- `DW`, default 8: operand width, two's complement.
- `N`, default 8: vector length and matrix dimension. Must be even and a power of two.

Ports:
- `clk`  input  1  sole clock; all logic on posedge.
- `reset_n`  input  1  synchronous, active-low reset, sampled on posedge `clk`.
- `start`  input  1  begins a frame; honoured only in IDLE.
- `in_data`  input  DW  operand word.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_ready`  output  1  feeder accepts a word this cycle. A word transfers when `in_valid & in_ready`.
- `mac_a1`  output  DW  A element for lane 1 (row 2k).
- `mac_a0`  output  DW  A element for lane 0 (row 2k+1).
- `mac_b`  output  DW  shared B element `B[j]`.
- `mac_en`  output  1  operands valid; both MACs consume this cycle.
- `mac_clr`  output  1  qualifies `mac_en`; MAC loads the product instead of accumulating (j==0).
- `pair_done`  output  1  asserted with the `mac_en` of j==N-1; results for row pair k are final next cycle.
- `pair_idx`  output  log2(N/2)  row-pair index k of the current `mac_en`.
- `busy`  output  1  high in LOAD_B and STREAM.
- `done`  output  1  one-cycle pulse at end of frame.

## Operation
- States and transitions:
  - IDLE → LOAD_B on `start`.
  - LOAD_B → STREAM after N accepted words.
  - STREAM → DONE after N·N accepted words.
  - DONE → IDLE unconditionally after one cycle.
- Frame order on `in_data`:
  - First, `B[0..N-1]`.
  - Then, for each k = 0..N/2-1 and j = 0..N-1: `A[2k][j]` followed by `A[2k+1][j]`.
  - Total frame length: N + N·N words (72 at defaults).
- LOAD_B:
  - Accepted word i is written to B register file entry i.
  - No MAC outputs are driven active.
- STREAM:
  - A 1-bit lane toggle selects the destination of each accepted word.
  - Even-position word: stored in a holding register.
  - Odd-position word completes a pair. On the next edge, register the following and pulse `mac_en` for one cycle:
    - `mac_a1` ← holding register.
    - `mac_a0` ← `in_data`.
    - `mac_b` ← `B[j]`.
    - `mac_clr` ← (j==0).
    - `pair_done` ← (j==N-1).
    - `pair_idx` ← k.
  - Then increment j. At wrap from N-1 to 0, increment k.
- `in_ready` = `busy`. There is no backpressure from the MACs, so they must accept one pair per cycle.
- `start` in any state other than IDLE is ignored.
- `in_valid` in IDLE or DONE is ignored; no words are accepted.
- Operands are passed unmodified. No sign extension is done here; the MAC performs signed DW×DW→2DW multiplication and a 2DW+log2(N)-bit (19-bit) sum.

## Timing
- Reset (`reset_n`=0 at an edge) forces the following; applies mid-frame with no flush:
  - State → IDLE.
  - All counters and the lane toggle cleared.
  - `mac_a1`, `mac_a0`, `mac_b` = 0.
  - `mac_en`, `mac_clr`, `pair_done`, `done`, `busy`, `in_ready` = 0.
  - `pair_idx` = 0.
  - B register file contents are don't-care.
- `start` sampled in cycle t → `busy` and `in_ready` high from t+1.
- Latency: the pair-completing transfer in cycle t produces `mac_en` in cycle t+1.
- `mac_en`, `mac_clr`, `pair_done` are single-cycle pulses. Operand outputs hold their last values when `mac_en`=0.
- Gaps (`in_valid`=0) stall the counters and the lane toggle. A gap between the two words of a pair is legal and preserves the holding register.
- Minimum frame time at full rate: 1 + 72 cycles from `start` to the last transfer.
  - Last `mac_en` (with `pair_done`=1, `pair_idx`=N/2-1) arrives one cycle after the last transfer.
  - `done` is asserted in the cycle after the last `mac_en`.
  - State is IDLE on the following cycle.
- `start` asserted in the same cycle as `done` is ignored. It is accepted one cycle later.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `in_valid`=1 and `start`=1 → all outputs 0, `in_ready`=0, no `mac_en`.
- **Full-rate frame with identity data:**
  - Stimulus: B = {1,2,3,4,5,6,7,8}; A = identity.
  - Required: exactly 32 `mac_en` pulses.
  - Required for k=0: j=0 gives `mac_a1`=1, `mac_a0`=0, `mac_b`=1, `mac_clr`=1; j=1 gives `mac_a1`=0, `mac_a0`=1, `mac_b`=2.
  - Required: `pair_done` on pulses 8, 16, 24, 32.
  - Required: `done` exactly 74 cycles after the `start` cycle.
- **Signed extremes:**
  - Stimulus: all B = -128 (8'h80); all A = 8'h80 and 8'h7F alternating.
  - Required: `mac_a1`=8'h80, `mac_a0`=8'h7F, `mac_b`=8'h80 on every pulse, unmodified.
  - Required (lanes attached): pair results +131072 and −130048.
- **Gaps:**
  - Stimulus: random `in_valid` at 50% duty, including a stall between the words of a pair.
  - Required: same operand sequence as the full-rate case.
  - Required: `mac_en` count = 32; `pair_idx` sequence 0,0,…,3.
- **Ignored start:** pulse `start` during STREAM → no restart; counters continue; `done` timing unchanged.
- **Mid-frame reset:**
  - Stimulus: assert `reset_n`=0 after 40 transfers, then start a fresh frame.
  - Required: the fresh frame begins with a B load.
  - Required: the first STREAM pulse has `mac_clr`=1, `pair_idx`=0.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Serial operand front end for a two-lane matrix-vector MAC: latches vector B,
// then splits the interleaved A stream into row pairs with a shared B element.
module mac_operand_feeder #(
  parameter int DW = 8,
  parameter int N  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [DW-1:0]                        in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DW-1:0]                        mac_a1,
  output logic [DW-1:0]                        mac_a0,
  output logic [DW-1:0]                        mac_b,
  output logic                                 mac_en,
  output logic                                 mac_clr,
  output logic                                 pair_done,
  output logic [((N > 2) ? $clog2(N/2) : 1)-1:0] pair_idx,
  output logic                                 busy,
  output logic                                 done
);
  localparam int JW = $clog2(N);
  localparam int KW = (N > 2) ? $clog2(N/2) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N-1);
  localparam logic [KW-1:0] K_LAST = KW'(N/2-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_B, S_STREAM, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [JW-1:0]         r_bcnt, r_j;
  logic [KW-1:0]         r_k;
  logic                  r_lane, r_last;
  logic [DW-1:0]         r_hold;
  logic [N-1:0][DW-1:0]  r_b;
  logic                  w_busy, w_xfer;

  assign w_xfer = in_valid & w_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // r_last holds STREAM one extra cycle so the final pair's mac_en drains before DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD_B;
      S_LOAD_B: if (w_xfer && r_bcnt == J_LAST) w_next = S_STREAM;
      S_STREAM: if (r_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_LOAD_B: w_busy = 1'b1;
      S_STREAM: w_busy = ~r_last;
      S_DONE:   done   = 1'b1;
      default:  ;
    endcase
    busy     = w_busy;
    in_ready = w_busy;
  end

  // B storage is not reset; it is fully rewritten at the start of every frame
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_B && w_xfer) r_b[r_bcnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bcnt    <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_lane    <= 1'b0;
      r_last    <= 1'b0;
      r_hold    <= '0;
      mac_a1    <= '0;
      mac_a0    <= '0;
      mac_b     <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      pair_done <= 1'b0;
      pair_idx  <= '0;
    end else begin
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      pair_done <= 1'b0;
      if (r_state == S_IDLE) begin
        r_bcnt <= '0;
        r_j    <= '0;
        r_k    <= '0;
        r_lane <= 1'b0;
        r_last <= 1'b0;
      end
      if (r_state == S_LOAD_B && w_xfer) r_bcnt <= r_bcnt + 1'b1;
      if (r_state == S_STREAM && w_xfer) begin
        r_lane <= ~r_lane;
        if (!r_lane) begin
          r_hold <= in_data;
        end else begin
          mac_a1    <= r_hold;
          mac_a0    <= in_data;
          mac_b     <= r_b[r_j];
          mac_en    <= 1'b1;
          mac_clr   <= (r_j == '0);
          pair_done <= (r_j == J_LAST);
          pair_idx  <= r_k;
          r_j       <= r_j + 1'b1;
          if (r_j == J_LAST) begin
            r_k <= r_k + 1'b1;
            if (r_k == K_LAST) r_last <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Frame-level bench: table of frame scenarios, scoreboard of expected MAC pulses,
// plus hand-written reset and mid-frame-reset sequences.
module tb_mac_operand_feeder;
  localparam int DW = 8;
  localparam int N  = 8;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, mac_en, mac_clr, pair_done, busy, done;
  logic [DW-1:0] mac_a1, mac_a0, mac_b;
  logic [1:0]    pair_idx;

  mac_operand_feeder #(.DW(DW), .N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mac_a1(mac_a1), .mac_a0(mac_a0),
    .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr), .pair_done(pair_done),
    .pair_idx(pair_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a1, a0, b;
    logic       clr, pd;
    logic [1:0] idx;
  } exp_t;

  typedef struct {
    string name;
    int    bmode;     // 0: 1..N, 1: all -128
    int    amode;     // 0: identity, 1: 0x80/0x7F rows, 2: random
    bit    gaps;
    bit    mid_start;
    int    exp_lat;   // start-to-done cycles, -1 = not checked
    bit    chk_const;
    int    exp1, exp0;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  logic signed [7:0] Bm[N];
  logic signed [7:0] Am[N][N];

  int n_vec = 0, n_err = 0;
  int ncyc = 0, t_start = 0, pulses = 0, pdones = 0, done_cnt = 0, lat_last = 0;
  int acc1 = 0, acc0 = 0;
  bit chk_const = 1'b0;
  int cexp1 = 0, cexp0 = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  exp_t e;
  int   r1, r0;
  always @(negedge clk) begin
    ncyc++;
    if (reset_n && start && !busy && !done) t_start = ncyc;
    if (done) begin
      done_cnt++;
      lat_last = ncyc - t_start;
    end
    if (mac_en) begin
      pulses++;
      acc1 = (mac_clr ? 0 : acc1) + int'($signed(mac_a1)) * int'($signed(mac_b));
      acc0 = (mac_clr ? 0 : acc0) + int'($signed(mac_a0)) * int'($signed(mac_b));
      if (sb.size() == 0) begin
        check("spurious_mac_en", 1, 0);
      end else begin
        e = sb.pop_front();
        check("mac_a1", mac_a1, e.a1);
        check("mac_a0", mac_a0, e.a0);
        check("mac_b", mac_b, e.b);
        check("mac_clr", mac_clr, e.clr);
        check("pair_done", pair_done, e.pd);
        check("pair_idx", pair_idx, e.idx);
        if (e.pd) begin
          pdones++;
          r1 = 0;
          r0 = 0;
          for (int j = 0; j < N; j++) begin
            r1 += int'(Am[2*e.idx][j]) * int'(Bm[j]);
            r0 += int'(Am[2*e.idx+1][j]) * int'(Bm[j]);
          end
          check("row_sum_lane1", acc1, r1);
          check("row_sum_lane0", acc0, r0);
          if (chk_const) begin
            check("const_sum_lane1", acc1, cexp1);
            check("const_sum_lane0", acc0, cexp0);
          end
        end
      end
    end
  end

  task automatic drive_word(input logic [7:0] w, input bit push, input exp_t ex,
                            input bit gaps, input bit force_gap, input bit mstart);
    int g = 0;
    int ng = 0;
    if (gaps) begin
      ng = force_gap ? 2 : $urandom_range(2, 0);
      repeat (ng) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = w;
    if (mstart) start = 1'b1;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g == 50) check("in_ready_timeout", 0, 1);
    if (push) sb.push_back(ex);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic build_data(input vec_t v);
    for (int j = 0; j < N; j++) Bm[j] = (v.bmode == 0) ? 8'(j + 1) : 8'h80;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (v.amode)
          0:       Am[i][j] = (i == j) ? 8'sd1 : 8'sd0;
          1:       Am[i][j] = (i % 2 == 0) ? 8'h80 : 8'h7F;
          default: Am[i][j] = 8'($urandom);
        endcase
  endtask

  // nw < N+N*N stops the frame early (used for the mid-frame reset)
  task automatic run_frame(input vec_t v, input int nw);
    exp_t ex;
    int   idx = 0;
    int   g = 0;
    int   d0;
    build_data(v);
    chk_const = v.chk_const;
    cexp1 = v.exp1;
    cexp0 = v.exp0;
    pulses = 0;
    pdones = 0;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({v.name, "_busy_after_start"}, busy, 1);
    ex = '{default: '0};
    for (int j = 0; j < N && idx < nw; j++) begin
      drive_word(Bm[j], 1'b0, ex, v.gaps, 1'b0, 1'b0);
      idx++;
    end
    for (int k = 0; k < N/2; k++)
      for (int j = 0; j < N; j++)
        for (int r = 0; r < 2; r++) begin
          if (idx < nw) begin
            ex.a1  = Am[2*k][j];
            ex.a0  = Am[2*k+1][j];
            ex.b   = Bm[j];
            ex.clr = (j == 0);
            ex.pd  = (j == N-1);
            ex.idx = 2'(k);
            drive_word(Am[2*k+r][j], r == 1, ex, v.gaps, idx == N+1,
                       v.mid_start && idx == 30);
            idx++;
          end
        end
    if (nw >= N + N*N) begin
      while (done_cnt == d0 && g < 20) begin @(negedge clk); g++; end
      check({v.name, "_done_seen"}, done_cnt - d0, 1);
      if (v.exp_lat >= 0) check({v.name, "_done_latency"}, lat_last, v.exp_lat);
      check({v.name, "_mac_en_count"}, pulses, 32);
      check({v.name, "_pair_done_count"}, pdones, 4);
      check({v.name, "_scoreboard_empty"}, sb.size(), 0);
      @(posedge clk); #1;
      check({v.name, "_idle_after_done"}, busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"identity",  0, 0, 1'b0, 1'b0, 74, 1'b0, 0, 0};
    vecs[1] = '{"extremes",  1, 1, 1'b0, 1'b0, 74, 1'b1, 131072, -130048};
    vecs[2] = '{"gaps",      0, 0, 1'b1, 1'b0, -1, 1'b0, 0, 0};
    vecs[3] = '{"ign_start", 0, 0, 1'b0, 1'b1, 74, 1'b0, 0, 0};
    vecs[4] = '{"random",    0, 2, 1'b1, 1'b0, -1, 1'b0, 0, 0};

    // reset held with start and in_valid active
    reset_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_unknown", $isunknown({mac_a1, mac_a0, mac_b, mac_en, mac_clr,
                                       pair_done, pair_idx, busy, done, in_ready}), 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_operands", {mac_a1, mac_a0, mac_b}, 0);
      check("rst_flags", {mac_clr, pair_done, pair_idx}, 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    check("idle_no_start_busy", busy, 0);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], N + N*N);

    // reset after 40 transfers, then a fresh full frame
    run_frame(vecs[0], 40);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_mac_en", mac_en, 0);
    check("midrst_sb_drained", sb.size(), 0);
    sb.delete();
    run_frame(vecs[0], N + N*N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
